// File: rtl/coreport_master.sv
// Wishbone classic single-transfer initiator driven by a valid/ready command
// stream; optional bus timeout is enabled by defining CORE_MASTER_TIMEOUT_EN.
module coreport_master #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned MAX_RETRY      = 3,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             wb_clk,
  input  logic             wb_rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_adr,
  input  logic [WIDTH-1:0] cmd_dat,
  input  logic             cmd_we,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_dat,
  output logic [1:0]       rsp_status,
  output logic             busy,
  output logic [31:0]      wb_adr_o,
  output logic [WIDTH-1:0] wb_dat_o,
  input  logic [WIDTH-1:0] wb_dat_i,
  output logic             wb_we_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic [2:0]       wb_cti_o,
  output logic [1:0]       wb_bte_o,
  input  logic             wb_ack_i,
  input  logic             wb_err_i,
  input  logic             wb_rty_i
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_BACKOFF, S_RESP} state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_ERR     = 2'b01;
  localparam logic [1:0] ST_RTY_EXH = 2'b10;
  localparam logic [3:0] MAX_R      = 4'(MAX_RETRY);

  state_t           state_q, state_d;
  logic [3:0]       retry_q, retry_d;
  logic             cyc_q, cyc_d;
  logic             we_q, we_d;
  logic [31:0]      adr_q, adr_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic [1:0]       rsp_status_q, rsp_status_d;
  logic             ack, err, rty;

`ifdef CORE_MASTER_TIMEOUT_EN
  localparam logic [1:0]  ST_TIMEOUT = 2'b11;
  localparam logic [15:0] TO_LAST    = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_q, to_d;
`endif

  // Terminations only count while our cycle is actually on the bus.
  assign ack = wb_ack_i & cyc_q;
  assign err = wb_err_i & cyc_q;
  assign rty = wb_rty_i & cyc_q;

  always_comb begin
    state_d      = state_q;
    retry_d      = retry_q;
    cyc_d        = cyc_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_dat_d    = rsp_dat_q;
    rsp_status_d = rsp_status_q;
`ifdef CORE_MASTER_TIMEOUT_EN
    to_d         = to_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          adr_d   = cmd_adr;
          dat_d   = cmd_dat;
          we_d    = cmd_we;
          retry_d = '0;
`ifdef CORE_MASTER_TIMEOUT_EN
          to_d    = '0;
`endif
          cyc_d   = 1'b1;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        if (err) begin
          rsp_status_d = ST_ERR;
          rsp_dat_d    = '0;
          rsp_valid_d  = 1'b1;
          cyc_d        = 1'b0;
          state_d      = S_RESP;
        end else if (ack) begin
          rsp_status_d = ST_OK;
          rsp_dat_d    = we_q ? '0 : wb_dat_i;
          rsp_valid_d  = 1'b1;
          cyc_d        = 1'b0;
          state_d      = S_RESP;
        end else if (rty) begin
          cyc_d = 1'b0;
          if (retry_q < MAX_R) begin
            retry_d = retry_q + 4'd1;
            state_d = S_BACKOFF;
          end else begin
            rsp_status_d = ST_RTY_EXH;
            rsp_dat_d    = '0;
            rsp_valid_d  = 1'b1;
            state_d      = S_RESP;
          end
        end
`ifdef CORE_MASTER_TIMEOUT_EN
        else if (to_q == TO_LAST) begin
          rsp_status_d = ST_TIMEOUT;
          rsp_dat_d    = '0;
          rsp_valid_d  = 1'b1;
          cyc_d        = 1'b0;
          state_d      = S_RESP;
        end else begin
          to_d = to_q + 16'd1;
        end
`endif
      end
      S_BACKOFF: begin
`ifdef CORE_MASTER_TIMEOUT_EN
        to_d    = '0;
`endif
        cyc_d   = 1'b1;
        state_d = S_BUS;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q      <= S_IDLE;
      retry_q      <= '0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= ST_OK;
`ifdef CORE_MASTER_TIMEOUT_EN
      to_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      retry_q      <= retry_d;
      cyc_q        <= cyc_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_dat_q    <= rsp_dat_d;
      rsp_status_q <= rsp_status_d;
`ifdef CORE_MASTER_TIMEOUT_EN
      to_q         <= to_d;
`endif
    end
  end

  // Gated by reset so no command is advertised while reset is held.
  assign cmd_ready  = (state_q == S_IDLE) && !wb_rst;
  assign busy       = (state_q != S_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_dat    = rsp_dat_q;
  assign rsp_status = rsp_status_q;
  assign wb_adr_o   = adr_q;
  assign wb_dat_o   = dat_q;
  assign wb_we_o    = we_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = cyc_q;
  assign wb_cti_o   = 3'b000;
  assign wb_bte_o   = 2'b00;

endmodule

// File: tb/tb_coreport_master.sv
// Directed self-checking bench for coreport_master with a small scripted
// Wishbone slave (loopback register file, err, rty, silent, rogue modes).
`timescale 1ns/1ps
module tb_coreport_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr;
  logic [7:0]  cmd_dat;
  logic        rsp_valid, rsp_ready;
  logic [7:0]  rsp_dat;
  logic [1:0]  rsp_status;
  logic        busy;
  logic [31:0] wb_adr_o;
  logic [7:0]  wb_dat_o, wb_dat_i;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic        wb_ack_i, wb_err_i, wb_rty_i;

  int n_cmp = 0;
  int n_bad = 0;

  // slave control: 0 zero-wait ack, 1 err, 2 rty rty_n times then ack, 3 silent, 4 rogue
  int  mode = 0;
  int  rty_n = 0;
  int  rty_seen;
  int  stb_cnt;
  bit  clr = 1'b0;
  logic [7:0] mem [16];

  coreport_master #(.WIDTH(8), .MAX_RETRY(3), .TIMEOUT_CYCLES(16)) dut (
    .wb_clk(clk), .wb_rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_adr(cmd_adr),
    .cmd_dat(cmd_dat), .cmd_we(cmd_we),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_status(rsp_status), .busy(busy),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  always #5 clk = ~clk;

  assign wb_dat_i = mem[wb_adr_o[5:2]];

  always_comb begin
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_rty_i = 1'b0;
    case (mode)
      0: wb_ack_i = wb_cyc_o & wb_stb_o;
      1: wb_err_i = wb_cyc_o & wb_stb_o;
      2: if (wb_cyc_o & wb_stb_o) begin
           if (rty_seen < rty_n) wb_rty_i = 1'b1;
           else                  wb_ack_i = 1'b1;
         end
      4: begin wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_rty_i = 1'b1; end
      default: ;
    endcase
  end

  always @(posedge clk) begin
    if (clr) begin
      rty_seen <= 0;
      stb_cnt  <= 0;
    end else begin
      if (wb_cyc_o & wb_stb_o) stb_cnt <= stb_cnt + 1;
      if (wb_cyc_o & wb_stb_o & wb_rty_i) rty_seen <= rty_seen + 1;
    end
    if (wb_cyc_o & wb_stb_o & wb_ack_i & wb_we_o) mem[wb_adr_o[5:2]] <= wb_dat_o;
  end

  // results of the last run_cmd
  logic [1:0]  r_st;
  logic [7:0]  r_rd;
  int          r_cyc_hi, r_lat;
  bit          r_got, r_cyc_at_rsp;
  logic [31:0] r_pat;
  logic [31:0] b_adr;
  logic [7:0]  b_dat;
  logic        b_we;

  task automatic run_cmd(input logic [31:0] adr, input logic [7:0] dat, input logic we,
                         input int budget);
    int k;
    bit first;
    @(negedge clk);
    clr = 1'b1; cmd_valid = 1'b1; cmd_adr = adr; cmd_dat = dat; cmd_we = we;
    k = 0;
    while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL cmd_accept: cmd_ready=%b required 1", cmd_ready);
    end
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0; cmd_valid = 1'b0;
    r_got = 1'b0; r_lat = 0; r_cyc_hi = 0; r_pat = '0; first = 1'b1;
    r_st = 'x; r_rd = 'x; r_cyc_at_rsp = 1'bx;
    while (!r_got && r_lat < budget) begin
      r_lat++;
      if (rsp_valid === 1'b1) begin
        r_got = 1'b1; r_st = rsp_status; r_rd = rsp_dat; r_cyc_at_rsp = wb_cyc_o;
      end else begin
        if (first) begin b_adr = wb_adr_o; b_dat = wb_dat_o; b_we = wb_we_o; first = 1'b0; end
        r_pat = {r_pat[30:0], wb_cyc_o};
        if (wb_cyc_o === 1'b1) r_cyc_hi++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_we = 1'b0; rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({cmd_ready, rsp_valid, busy, wb_cyc_o, wb_stb_o, wb_we_o} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctrl: rdy/vld/busy/cyc/stb/we=%b required 000000",
                        {cmd_ready, rsp_valid, busy, wb_cyc_o, wb_stb_o, wb_we_o});
    end
    n_cmp++;
    if ({wb_adr_o, wb_dat_o, rsp_dat, rsp_status} !== 50'b0) begin
      n_bad++; $display("FAIL reset_data: adr=%h dat=%h rsp_dat=%h st=%b required all 0",
                        wb_adr_o, wb_dat_o, rsp_dat, rsp_status);
    end
    n_cmp++;
    if ({wb_cti_o, wb_bte_o} !== 5'b0) begin
      n_bad++; $display("FAIL cti_bte: %b required 00000", {wb_cti_o, wb_bte_o});
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_bad++; $display("FAIL idle_after_reset: cmd_ready=%b busy=%b required 1 0", cmd_ready, busy);
    end
  endtask

  task automatic test_ignore_when_idle();
    bit bad = 1'b0;
    mode = 4;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || busy !== 1'b0 || wb_cyc_o !== 1'b0) bad = 1'b1;
    end
    mode = 0;
    n_cmp++;
    if (bad) begin n_bad++; $display("FAIL ignore_idle_term: response/busy seen, required none"); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] adrs [3] = '{32'h04, 32'h00, 32'h00};
    logic [7:0]  dats [3] = '{8'hFF, 8'hA5, 8'h00};
    logic        wes  [3] = '{1'b1, 1'b1, 1'b0};
    logic [7:0]  exp_rd [3] = '{8'h00, 8'h00, 8'hA5};
    mode = 0; rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_cmd(adrs[i], dats[i], wes[i], 20);
      n_cmp++;
      if (r_got !== 1'b1 || r_st !== 2'b00 || r_rd !== exp_rd[i]) begin
        n_bad++; $display("FAIL zw_rsp%0d: got=%b st=%b dat=%h required 1 00 %h",
                          i, r_got, r_st, r_rd, exp_rd[i]);
      end
      n_cmp++;
      if (r_cyc_hi !== 1 || r_lat !== 2) begin
        n_bad++; $display("FAIL zw_timing%0d: cyc_hi=%0d lat=%0d required 1 2", i, r_cyc_hi, r_lat);
      end
      n_cmp++;
      if (b_adr !== adrs[i] || b_we !== wes[i] || (wes[i] && b_dat !== dats[i])) begin
        n_bad++; $display("FAIL zw_bus%0d: adr=%h we=%b dat=%h required %h %b %h",
                          i, b_adr, b_we, b_dat, adrs[i], wes[i], dats[i]);
      end
      @(negedge clk);
      n_cmp++;
      if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
        n_bad++; $display("FAIL zw_ready%0d: cmd_ready=%b rsp_valid=%b required 1 0",
                          i, cmd_ready, rsp_valid);
      end
    end
  endtask

  task automatic test_err();
    mode = 1;
    run_cmd(32'h20, 8'h00, 1'b0, 20);
    n_cmp++;
    if (r_got !== 1'b1 || r_st !== 2'b01 || r_rd !== 8'h00 || r_cyc_at_rsp !== 1'b0 || r_lat !== 2) begin
      n_bad++; $display("FAIL err: got=%b st=%b dat=%h cyc=%b lat=%0d required 1 01 00 0 2",
                        r_got, r_st, r_rd, r_cyc_at_rsp, r_lat);
    end
    mode = 0;
  endtask

  task automatic test_retry();
    mode = 2; rty_n = 3;
    run_cmd(32'h00, 8'h00, 1'b0, 40);
    n_cmp++;
    if (r_got !== 1'b1 || r_st !== 2'b00 || r_rd !== 8'hA5) begin
      n_bad++; $display("FAIL retry_ok: got=%b st=%b dat=%h required 1 00 a5", r_got, r_st, r_rd);
    end
    n_cmp++;
    if (r_pat !== 32'b1010101 || r_lat !== 8 || stb_cnt !== 4) begin
      n_bad++; $display("FAIL retry_pattern: pat=%b lat=%0d strobes=%0d required 1010101 8 4",
                        r_pat, r_lat, stb_cnt);
    end
    rty_n = 4;
    run_cmd(32'h00, 8'h00, 1'b0, 40);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (r_got !== 1'b1 || r_st !== 2'b10 || r_rd !== 8'h00) begin
      n_bad++; $display("FAIL retry_exh: got=%b st=%b dat=%h required 1 10 00", r_got, r_st, r_rd);
    end
    n_cmp++;
    if (r_pat !== 32'b1010101 || stb_cnt !== 4) begin
      n_bad++; $display("FAIL retry_exh_strobes: pat=%b strobes=%0d required 1010101 4", r_pat, stb_cnt);
    end
    mode = 0;
  endtask

  task automatic test_timeout();
    mode = 3;
`ifdef CORE_MASTER_TIMEOUT_EN
    run_cmd(32'h00, 8'h00, 1'b0, 100);
    n_cmp++;
    if (r_got !== 1'b1 || r_st !== 2'b11 || r_rd !== 8'h00) begin
      n_bad++; $display("FAIL timeout_rsp: got=%b st=%b dat=%h required 1 11 00", r_got, r_st, r_rd);
    end
    n_cmp++;
    if (r_cyc_hi !== 16 || r_lat !== 17) begin
      n_bad++; $display("FAIL timeout_len: cyc_hi=%0d lat=%0d required 16 17", r_cyc_hi, r_lat);
    end
`else
    run_cmd(32'h00, 8'h00, 1'b0, 1000);
    n_cmp++;
    if (r_got !== 1'b0 || r_cyc_hi !== 1000) begin
      n_bad++; $display("FAIL no_timeout: got=%b cyc_hi=%0d required 0 1000", r_got, r_cyc_hi);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    mode = 0;
  endtask

  task automatic test_backpressure();
    bit bad = 1'b0;
    mode = 0; rsp_ready = 1'b0;
    run_cmd(32'h00, 8'h00, 1'b0, 20);
    n_cmp++;
    if (r_got !== 1'b1 || r_st !== 2'b00 || r_rd !== 8'hA5) begin
      n_bad++; $display("FAIL bp_rsp: got=%b st=%b dat=%h required 1 00 a5", r_got, r_st, r_rd);
    end
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_dat !== 8'hA5 || rsp_status !== 2'b00 || cmd_ready !== 1'b0)
        bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin n_bad++; $display("FAIL bp_hold: response not held or cmd_ready high, required held/0"); end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL bp_release: rsp_valid=%b cmd_ready=%b required 0 1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset_mid_bus();
    bit bad = 1'b0;
    mode = 3;
    @(negedge clk);
    clr = 1'b1; cmd_valid = 1'b1; cmd_adr = 32'h08; cmd_dat = 8'h3C; cmd_we = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0; cmd_valid = 1'b0;
    n_cmp++;
    if (wb_cyc_o !== 1'b1) begin n_bad++; $display("FAIL mid_bus_cyc: cyc=%b required 1", wb_cyc_o); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL async_reset: cyc=%b stb=%b busy=%b required 0 0 0", wb_cyc_o, wb_stb_o, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || wb_cyc_o !== 1'b0) bad = 1'b1;
    end
    n_cmp++;
    if (bad) begin n_bad++; $display("FAIL after_reset: response or cycle seen, required none"); end
    mode = 0;
    run_cmd(32'h08, 8'h3C, 1'b1, 20);
    run_cmd(32'h08, 8'h00, 1'b0, 20);
    n_cmp++;
    if (r_got !== 1'b1 || r_st !== 2'b00 || r_rd !== 8'h3C || r_lat !== 2) begin
      n_bad++; $display("FAIL post_reset_txn: got=%b st=%b dat=%h lat=%0d required 1 00 3c 2",
                        r_got, r_st, r_rd, r_lat);
    end
  endtask

  initial begin
    test_reset();
    test_ignore_when_idle();
    test_zero_wait();
    test_err();
    test_retry();
    test_timeout();
    test_backpressure();
    test_reset_mid_bus();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
